// File: rtl/radiant_thresh_scan_ctrl.sv
// Threshold-scan sequencer for the RADIANT trigger path: steps PWM threshold DACs over a range,
// measures per-channel scaler counts over a gate and streams (channel, threshold, count) results.
module radiant_thresh_scan_ctrl #(
  parameter int unsigned NUM_CH       = 24,
  parameter int unsigned THRESH_WIDTH = 16,
  parameter int unsigned COUNT_WIDTH  = 16,
  parameter int unsigned SETTLE_WIDTH = 16,
  parameter int unsigned GATE_WIDTH   = 24
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [NUM_CH-1:0]       ch_mask_i,
  input  logic [THRESH_WIDTH-1:0] thresh_start_i,
  input  logic [THRESH_WIDTH-1:0] thresh_stop_i,
  input  logic [THRESH_WIDTH-1:0] thresh_step_i,
  input  logic [SETTLE_WIDTH-1:0] settle_cycles_i,
  input  logic [GATE_WIDTH-1:0]   gate_cycles_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    aborted_o,
  output logic                    thresh_wr_o,
  output logic [4:0]              thresh_ch_o,
  output logic [THRESH_WIDTH-1:0] thresh_dat_o,
  input  logic                    thresh_ack_i,
  input  logic [NUM_CH-1:0]       scal_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [4:0]              res_ch_o,
  output logic [THRESH_WIDTH-1:0] res_thresh_o,
  output logic [COUNT_WIDTH-1:0]  res_count_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StSettle,
    StGate,
    StReport,
    StNext
  } state_e;

  state_e state_q, state_d;

  logic [NUM_CH-1:0]       mask_q;
  logic [THRESH_WIDTH-1:0] stop_q, step_q;
  logic [SETTLE_WIDTH-1:0] settle_q;
  logic [GATE_WIDTH-1:0]   gate_q;
  logic                    lat_cfg;

  logic [THRESH_WIDTH-1:0] cur_q, cur_d;
  logic [SETTLE_WIDTH-1:0] settle_left_q, settle_left_d;
  logic [GATE_WIDTH-1:0]   gate_left_q, gate_left_d;

  logic                    busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic                    wr_q, wr_d;
  logic [4:0]              wch_q, wch_d;
  logic [THRESH_WIDTH-1:0] wdat_q, wdat_d;
  logic                    valid_q, valid_d;
  logic [4:0]              rch_q, rch_d;
  logic [THRESH_WIDTH-1:0] rthr_q, rthr_d;
  logic [COUNT_WIDTH-1:0]  rcnt_q, rcnt_d;

  logic [COUNT_WIDTH-1:0]  cnt_q    [NUM_CH];
  logic [COUNT_WIDTH-1:0]  cnt_next [NUM_CH];
  logic                    cnt_clr, cnt_en;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [5:0] find_ch(input logic [NUM_CH-1:0] m, input logic [5:0] from);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (!r[5] && m[i] && (i >= int'(from))) begin
        r = {1'b1, 5'(i)};
      end
    end
    return r;
  endfunction

  logic [5:0] first_cfg, first_ch, next_wr, next_res;
  assign first_cfg = find_ch(ch_mask_i, 6'd0);
  assign first_ch  = find_ch(mask_q, 6'd0);
  assign next_wr   = find_ch(mask_q, {1'b0, wch_q} + 6'd1);
  assign next_res  = find_ch(mask_q, {1'b0, rch_q} + 6'd1);

  // Extra bit catches overflow past the top of the code range.
  logic [THRESH_WIDTH-1:0] step_eff;
  logic [THRESH_WIDTH:0]   nxt;
  logic                    last_step;
  assign step_eff  = (step_q == '0) ? THRESH_WIDTH'(1) : step_q;
  assign nxt       = {1'b0, cur_q} + {1'b0, step_eff};
  assign last_step = nxt[THRESH_WIDTH] || (nxt[THRESH_WIDTH-1:0] > stop_q);

  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cnt_next[i] = cnt_q[i];
      if (cnt_en && scal_i[i] && (cnt_q[i] != '1)) begin
        cnt_next[i] = cnt_q[i] + COUNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    settle_left_d = settle_left_q;
    gate_left_d   = gate_left_q;
    wr_d          = wr_q;
    wch_d         = wch_q;
    wdat_d        = wdat_q;
    valid_d       = valid_q;
    rch_d         = rch_q;
    rthr_d        = rthr_q;
    rcnt_d        = rcnt_q;
    done_d        = 1'b0;
    aborted_d     = 1'b0;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    lat_cfg       = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          lat_cfg = 1'b1;
          if (first_cfg[5]) begin
            state_d = StWrite;
            cur_d   = thresh_start_i;
            wr_d    = 1'b1;
            wch_d   = first_cfg[4:0];
            wdat_d  = thresh_start_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StWrite: begin
        if (thresh_ack_i) begin
          if (next_wr[5]) begin
            wch_d = next_wr[4:0];
          end else begin
            wr_d          = 1'b0;
            state_d       = StSettle;
            settle_left_d = settle_q;
          end
        end
      end
      StSettle: begin
        if (settle_left_q <= SETTLE_WIDTH'(1)) begin
          state_d     = StGate;
          cnt_clr     = 1'b1;
          gate_left_d = gate_q;
        end else begin
          settle_left_d = settle_left_q - SETTLE_WIDTH'(1);
        end
      end
      StGate: begin
        // A zero gate still transits this state once, with counting disabled.
        cnt_en = (gate_q != '0);
        if (gate_left_q <= GATE_WIDTH'(1)) begin
          state_d = StReport;
          valid_d = first_ch[5];
          rch_d   = first_ch[4:0];
          rthr_d  = cur_q;
          rcnt_d  = cnt_next[first_ch[4:0]];
        end else begin
          gate_left_d = gate_left_q - GATE_WIDTH'(1);
        end
      end
      StReport: begin
        if (res_ready_i) begin
          if (next_res[5]) begin
            rch_d  = next_res[4:0];
            rcnt_d = cnt_q[next_res[4:0]];
          end else begin
            valid_d = 1'b0;
            if (last_step) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              cur_d   = nxt[THRESH_WIDTH-1:0];
              state_d = StNext;
            end
          end
        end
      end
      StNext: begin
        state_d = StWrite;
        wr_d    = first_ch[5];
        wch_d   = first_ch[4:0];
        wdat_d  = cur_q;
      end
      default: state_d = StIdle;
    endcase

    if ((state_q != StIdle) && abort_i) begin
      state_d   = StIdle;
      aborted_d = 1'b1;
      done_d    = 1'b0;
      wr_d      = 1'b0;
      valid_d   = 1'b0;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      cur_q         <= '0;
      settle_left_q <= '0;
      gate_left_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      wr_q          <= 1'b0;
      wch_q         <= '0;
      wdat_q        <= '0;
      valid_q       <= 1'b0;
      rch_q         <= '0;
      rthr_q        <= '0;
      rcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      settle_left_q <= settle_left_d;
      gate_left_q   <= gate_left_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      wr_q          <= wr_d;
      wch_q         <= wch_d;
      wdat_q        <= wdat_d;
      valid_q       <= valid_d;
      rch_q         <= rch_d;
      rthr_q        <= rthr_d;
      rcnt_q        <= rcnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q   <= '0;
      stop_q   <= '0;
      step_q   <= '0;
      settle_q <= '0;
      gate_q   <= '0;
    end else if (lat_cfg) begin
      mask_q   <= ch_mask_i;
      stop_q   <= thresh_stop_i;
      step_q   <= thresh_step_i;
      settle_q <= settle_cycles_i;
      gate_q   <= gate_cycles_i;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (rst_i || cnt_clr) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_next[i];
      end
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign aborted_o    = aborted_q;
  assign thresh_wr_o  = wr_q;
  assign thresh_ch_o  = wch_q;
  assign thresh_dat_o = wdat_q;
  assign res_valid_o  = valid_q;
  assign res_ch_o     = rch_q;
  assign res_thresh_o = rthr_q;
  assign res_count_o  = rcnt_q;

endmodule

// File: tb/tb_radiant_thresh_scan_ctrl.sv
// Scoreboard bench for radiant_thresh_scan_ctrl: expected writes/results are queued at stimulus
// time and popped by a monitor on every accepted write or result transfer.
module tb_radiant_thresh_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_i, start_i, abort_i;
  logic [23:0] ch_mask_i;
  logic [15:0] thresh_start_i, thresh_stop_i, thresh_step_i, settle_cycles_i;
  logic [23:0] gate_cycles_i;
  logic        busy_o, done_o, aborted_o, thresh_wr_o, thresh_ack_i;
  logic [4:0]  thresh_ch_o, res_ch_o;
  logic [15:0] thresh_dat_o, res_thresh_o, res_count_o;
  logic [23:0] scal_i;
  logic        res_valid_o, res_ready_i;

  radiant_thresh_scan_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .ch_mask_i      (ch_mask_i),
    .thresh_start_i (thresh_start_i),
    .thresh_stop_i  (thresh_stop_i),
    .thresh_step_i  (thresh_step_i),
    .settle_cycles_i(settle_cycles_i),
    .gate_cycles_i  (gate_cycles_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .aborted_o      (aborted_o),
    .thresh_wr_o    (thresh_wr_o),
    .thresh_ch_o    (thresh_ch_o),
    .thresh_dat_o   (thresh_dat_o),
    .thresh_ack_i   (thresh_ack_i),
    .scal_i         (scal_i),
    .res_valid_o    (res_valid_o),
    .res_ready_i    (res_ready_i),
    .res_ch_o       (res_ch_o),
    .res_thresh_o   (res_thresh_o),
    .res_count_o    (res_count_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int exp_abort = 0;

  logic [20:0] exp_wr[$];
  logic [36:0] exp_res[$];

  int   cfg_settle, cfg_gate, cfg_mode, last_ch;
  bit   ack_rand = 0, ready_rand = 0;
  logic ready_force = 1'b1;
  int   ack_wait = 0;
  event gate_ev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int ch, input logic [15:0] dat);
    exp_wr.push_back({5'(ch), dat});
  endtask

  task automatic push_res(input int ch, input logic [15:0] thr, input logic [15:0] cnt);
    exp_res.push_back({5'(ch), thr, cnt});
  endtask

  task automatic start_scan(input logic [23:0] m, input logic [15:0] s, input logic [15:0] e,
                            input logic [15:0] st, input int se, input int g);
    step();
    ch_mask_i       = m;
    thresh_start_i  = s;
    thresh_stop_i   = e;
    thresh_step_i   = st;
    settle_cycles_i = 16'(se);
    gate_cycles_i   = 24'(g);
    cfg_settle      = se;
    cfg_gate        = g;
    start_i         = 1'b1;
    step();
    start_i         = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 64'(done_cnt), 64'(d0 + 1));
  endtask

  task automatic end_test();
    repeat (3) step();
    check("wr_q_empty", 64'(exp_wr.size()), 64'd0);
    check("res_q_empty", 64'(exp_res.size()), 64'd0);
    check("abort_cnt", 64'(abort_cnt), 64'(exp_abort));
  endtask

  // Scaler activity during the gate window, per test mode.
  function automatic logic [23:0] pat(input int mode, input int k);
    logic [23:0] r = '0;
    case (mode)
      0: r[0] = (k % 100 == 5) && (k < 700);
      1: r[3] = 1'b1;
      2: begin
        r[1] = 1'b1;
        r[4] = (k < 5);
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Noise on every channel during settle and the cycle after the gate must never be counted.
  initial begin
    scal_i = '0;
    forever begin
      @(gate_ev);
      @(posedge clk);
      repeat ((cfg_settle == 0) ? 1 : cfg_settle) begin
        #1 scal_i = '1;
        @(posedge clk);
      end
      for (int k = 0; k < cfg_gate; k++) begin
        #1 scal_i = pat(cfg_mode, k);
        @(posedge clk);
      end
      #1 scal_i = '1;
      @(posedge clk);
      #1 scal_i = '0;
    end
  end

  initial begin
    thresh_ack_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!ack_rand) begin
        thresh_ack_i = 1'b1;
      end else if (thresh_ack_i) begin
        thresh_ack_i = 1'b0;
        ack_wait = $urandom_range(0, 5);
      end else if (ack_wait == 0) begin
        thresh_ack_i = 1'b1;
      end else begin
        ack_wait--;
      end
    end
  end

  initial begin
    res_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1 res_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  logic        pv = 1'b0, pr = 1'b0;
  logic [36:0] pdat = '0;

  always @(negedge clk) begin
    if (!rst_i) begin
      if (thresh_wr_o && thresh_ack_i) begin
        if (exp_wr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wr_extra: got ch=%0d dat=%0h want no write", thresh_ch_o, thresh_dat_o);
        end else begin
          check("wr", 64'({thresh_ch_o, thresh_dat_o}), 64'(exp_wr.pop_front()));
        end
        if (int'(thresh_ch_o) == last_ch) -> gate_ev;
      end
      if (res_valid_o && res_ready_i) begin
        if (exp_res.size() == 0) begin
          total++;
          bad++;
          $display("FAIL res_extra: got ch=%0d thr=%0h cnt=%0h want no result",
                   res_ch_o, res_thresh_o, res_count_o);
        end else begin
          check("res", 64'({res_ch_o, res_thresh_o, res_count_o}), 64'(exp_res.pop_front()));
        end
      end
      if (pv && !pr && !aborted_o) begin
        check("res_hold", 64'({res_valid_o, res_ch_o, res_thresh_o, res_count_o}),
              64'({1'b1, pdat}));
      end
      if (done_o) done_cnt++;
      if (aborted_o) abort_cnt++;
      pv   = res_valid_o;
      pr   = res_ready_i;
      pdat = {res_ch_o, res_thresh_o, res_count_o};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    ch_mask_i = '0; thresh_start_i = '0; thresh_stop_i = '0; thresh_step_i = '0;
    settle_cycles_i = '0; gate_cycles_i = '0;
    cfg_settle = 0; cfg_gate = 0; cfg_mode = 0; last_ch = 99;
    repeat (3) step();
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_aborted", 64'(aborted_o), 64'd0);
    check("rst_wr", 64'(thresh_wr_o), 64'd0);
    check("rst_valid", 64'(res_valid_o), 64'd0);
    check("rst_outs", 64'({thresh_ch_o, thresh_dat_o, res_ch_o, res_thresh_o, res_count_o}), 64'd0);

    // Basic three-step scan with an ignored mid-scan start and mask change.
    cfg_mode = 0; last_ch = 2;
    for (int t = 100; t <= 300; t += 100) begin
      push_wr(0, 16'(t)); push_wr(2, 16'(t));
      push_res(0, 16'(t), 16'd7); push_res(2, 16'(t), 16'd0);
    end
    d0 = done_cnt;
    start_scan(24'h000005, 16'd100, 16'd300, 16'd100, 10, 1000);
    @(negedge clk);
    check("start_busy", 64'(busy_o), 64'd1);
    check("start_wr", 64'(thresh_wr_o), 64'd1);
    repeat (5) step();
    start_i = 1'b1; ch_mask_i = '1; thresh_start_i = 16'd0; gate_cycles_i = 24'd1;
    step();
    start_i = 1'b0;
    wait_done(6000);
    check("busy_after_done", 64'(busy_o), 64'd0);
    end_test();
    check("done_once", 64'(done_cnt), 64'(d0 + 1));

    // Zero mask finishes immediately.
    d0 = done_cnt;
    start_scan(24'h000000, 16'd1, 16'd2, 16'd1, 5, 5);
    @(negedge clk);
    check("zero_mask_done", 64'({done_o, busy_o, thresh_wr_o}), 64'b100);
    end_test();
    check("zero_mask_done_cnt", 64'(done_cnt), 64'(d0 + 1));

    // Start above stop: single step at start value; zero settle.
    last_ch = 1;
    push_wr(1, 16'd500); push_res(1, 16'd500, 16'd0);
    start_scan(24'h000002, 16'd500, 16'd200, 16'd100, 0, 4);
    wait_done(200);
    end_test();

    // Near the top of the code range: no wrap; zero gate counts nothing.
    last_ch = 23;
    push_wr(23, 16'hFFF0); push_res(23, 16'hFFF0, 16'd0);
    start_scan(24'h800000, 16'hFFF0, 16'hFFFF, 16'h0020, 1, 0);
    wait_done(200);
    end_test();

    // Backpressure on both handshakes; zero step behaves as one.
    cfg_mode = 2; last_ch = 11; ack_rand = 1; ready_rand = 1;
    for (int t = 10; t <= 12; t++) begin
      push_wr(1, 16'(t)); push_wr(4, 16'(t)); push_wr(11, 16'(t));
      push_res(1, 16'(t), 16'd20); push_res(4, 16'(t), 16'd5); push_res(11, 16'(t), 16'd0);
    end
    start_scan(24'h000812, 16'd10, 16'd12, 16'd0, 3, 20);
    wait_done(3000);
    ack_rand = 0; ready_rand = 0;
    end_test();

    // Saturating counter.
    cfg_mode = 1; last_ch = 3;
    push_wr(3, 16'h0040); push_res(3, 16'h0040, 16'hFFFF);
    start_scan(24'h000008, 16'h0040, 16'h0040, 16'd1, 2, 70000);
    wait_done(80000);
    end_test();

    // Abort during GATE.
    cfg_mode = 0; last_ch = 0;
    d0 = done_cnt;
    push_wr(0, 16'd7);
    start_scan(24'h000001, 16'd7, 16'd7, 16'd1, 2, 50);
    repeat (15) step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    exp_abort++;
    @(negedge clk);
    check("abort_gate_state", 64'({busy_o, aborted_o, res_valid_o, thresh_wr_o}), 64'b0100);
    @(negedge clk);
    check("abort_gate_pulse", 64'(aborted_o), 64'd0);
    repeat (60) step();
    check("abort_gate_no_done", 64'(done_cnt), 64'(d0));
    end_test();

    // Abort while a result is stalled.
    ready_force = 1'b0; last_ch = 1;
    d0 = done_cnt;
    push_wr(0, 16'd9); push_wr(1, 16'd9);
    start_scan(24'h000003, 16'd9, 16'd9, 16'd1, 1, 5);
    n = 0;
    while (!res_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("report_reached", 64'(res_valid_o), 64'd1);
    repeat (3) step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    exp_abort++;
    @(negedge clk);
    check("abort_rep_state", 64'({busy_o, aborted_o, res_valid_o}), 64'b010);
    @(negedge clk);
    check("abort_rep_pulse", 64'(aborted_o), 64'd0);
    ready_force = 1'b1;
    repeat (5) step();
    check("abort_rep_no_done", 64'(done_cnt), 64'(d0));
    end_test();

    // A fresh scan runs normally after an abort.
    last_ch = 0;
    push_wr(0, 16'd1); push_res(0, 16'd1, 16'd0);
    start_scan(24'h000001, 16'd1, 16'd1, 16'd1, 0, 2);
    wait_done(200);
    end_test();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
